led_pattern_engine: RTL and testbench

Parametrised LED pattern generator that drives a WIDTH-bit LED bank from eight selectable animations. It has a four-level programmable frame rate, direction control, pause with single-step, and a frame-advance strobe. It is the next-generation replacement for the fixed 8-LED, two-speed pattern generator. It sits directly behind the top-level pin wrapper, which maps `ui_in` onto the control inputs and `led_out` onto `uo_out`.

---
 rtl/led_pattern_engine.sv | 193 +++++++++++++++++++
 tb/tb_led_pattern_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// WIDTH-bit LED animation engine: eight patterns, a programmable frame prescaler,
// pause with single-step, and a one-cycle frame_tick on every advance.
module led_pattern_engine #(
  parameter int WIDTH    = 8,
  parameter int BASE_DIV = 3_125_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       pat_sel,
  input  logic [1:0]       speed,
  input  logic             dir,
  input  logic             pause,
  input  logic             step,
  output logic [WIDTH-1:0] led_out,
  output logic             frame_tick
);

  // pattern | meaning
  // OFF     | constant zero
  // WALK1   | rotating single one
  // WALK0   | rotating single zero
  // PING    | one bouncing between the ends, each end shown once
  // COUNT   | binary up/down counter
  // BAR     | bar fills to all-ones then empties
  // BLINK   | all-ones / all-zeros alternation
  // LFSR    | Fibonacci LFSR, zero state recovers to 1
  typedef enum logic [2:0] {
    PAT_OFF   = 3'd0,
    PAT_WALK1 = 3'd1,
    PAT_WALK0 = 3'd2,
    PAT_PING  = 3'd3,
    PAT_COUNT = 3'd4,
    PAT_BAR   = 3'd5,
    PAT_BLINK = 3'd6,
    PAT_LFSR  = 3'd7
  } pat_e;

  localparam int PW = $clog2(BASE_DIV * 8);
  localparam int KW = $clog2(2 * WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] led_q, led_d;
  logic [PW-1:0]    presc_q, presc_d;
  pat_e             pat_q, pat_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic             step_r, step_q;
  logic             ping_up_q, ping_up_d;
  logic [KW-1:0]    bar_k_q, bar_k_d;

  logic [WIDTH-1:0] adv_img;
  logic             adv_up;
  logic [KW-1:0]    adv_k;
  logic [31:0]      term_cnt;
  logic             term_hit;
  logic             step_edge;
  logic             load_req;
  logic             do_adv;
  logic             lfsr_fb;

  function automatic logic [WIDTH-1:0] seed_of(input pat_e p);
    logic [WIDTH-1:0] s;
    case (p)
      PAT_WALK1: s = WIDTH'(1);
      PAT_WALK0: s = ~WIDTH'(1);
      PAT_PING:  s = WIDTH'(1);
      PAT_BLINK: s = '1;
      PAT_LFSR:  s = WIDTH'(1);
      default:   s = '0;
    endcase
    return s;
  endfunction

  // Bar image for step k: k ones while filling, 2*WIDTH-k while emptying.
  function automatic logic [WIDTH-1:0] bar_img(input logic [KW-1:0] k);
    int n;
    n = (int'(k) <= WIDTH) ? int'(k) : (2 * WIDTH - int'(k));
    return ~({WIDTH{1'b1}} << n);
  endfunction

  assign term_cnt  = (32'(BASE_DIV) << speed) - 32'd1;
  assign term_hit  = 32'(presc_q) >= term_cnt;
  assign step_edge = step_r & ~step_q;
  assign load_req  = !valid_q || (pat_sel != pat_q);
  assign lfsr_fb   = led_q[WIDTH-1] ^ led_q[WIDTH-3] ^ led_q[WIDTH-4] ^ led_q[WIDTH-5];

  always_comb begin
    adv_img = led_q;
    adv_up  = ping_up_q;
    adv_k   = bar_k_q;
    case (pat_q)
      PAT_OFF: adv_img = '0;
      PAT_WALK1, PAT_WALK0: begin
        if (dir) adv_img = {led_q[0], led_q[WIDTH-1:1]};
        else     adv_img = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
      end
      PAT_PING: begin
        if (ping_up_q) begin
          if (led_q[WIDTH-1]) begin
            adv_img = led_q >> 1;
            adv_up  = 1'b0;
          end else begin
            adv_img = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            adv_img = led_q << 1;
            adv_up  = 1'b1;
          end else begin
            adv_img = led_q >> 1;
          end
        end
      end
      PAT_COUNT: adv_img = dir ? (led_q - WIDTH'(1)) : (led_q + WIDTH'(1));
      PAT_BAR: begin
        adv_k   = (bar_k_q == K_LAST) ? '0 : (bar_k_q + KW'(1));
        adv_img = bar_img(adv_k);
      end
      PAT_BLINK: adv_img = ~led_q;
      PAT_LFSR: begin
        if (led_q == '0) adv_img = WIDTH'(1);
        else             adv_img = {led_q[WIDTH-2:0], lfsr_fb};
      end
      default: adv_img = '0;
    endcase
  end

  // Load beats pause/step/advance; everything freezes while ena is low.
  always_comb begin
    led_d     = led_q;
    presc_d   = presc_q;
    pat_d     = pat_q;
    valid_d   = valid_q;
    tick_d    = 1'b0;
    ping_up_d = ping_up_q;
    bar_k_d   = bar_k_q;
    do_adv    = 1'b0;
    if (ena) begin
      if (load_req) begin
        led_d     = seed_of(pat_e'(pat_sel));
        pat_d     = pat_e'(pat_sel);
        valid_d   = 1'b1;
        presc_d   = '0;
        ping_up_d = 1'b1;
        bar_k_d   = '0;
      end else if (pause) begin
        do_adv = step_edge;
      end else if (term_hit) begin
        do_adv = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      if (do_adv) begin
        led_d     = adv_img;
        ping_up_d = adv_up;
        bar_k_d   = adv_k;
        presc_d   = '0;
        tick_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      presc_q   <= '0;
      pat_q     <= PAT_OFF;
      valid_q   <= 1'b0;
      tick_q    <= 1'b0;
      step_r    <= 1'b0;
      step_q    <= 1'b0;
      ping_up_q <= 1'b1;
      bar_k_q   <= '0;
    end else begin
      led_q     <= led_d;
      presc_q   <= presc_d;
      pat_q     <= pat_d;
      valid_q   <= valid_d;
      tick_q    <= tick_d;
      ping_up_q <= ping_up_d;
      bar_k_q   <= bar_k_d;
      if (ena) begin
        step_r <= step;
        step_q <= step_r;
      end
    end
  end

  assign led_out    = led_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (WIDTH=8, BASE_DIV=4): stimulus pushes
// expected frames with their tick cycle, a monitor pops them on every frame_tick.
module tb_led_pattern_engine;
  localparam int W  = 8;
  localparam int BD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic [2:0]   pat_sel = 3'd0;
  logic [1:0]   speed = 2'd0;
  logic         dir = 1'b0;
  logic         pause = 1'b0;
  logic         step = 1'b0;
  logic [W-1:0] led_out;
  logic         frame_tick;

  led_pattern_engine #(.WIDTH(W), .BASE_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pat_sel(pat_sel), .speed(speed),
    .dir(dir), .pause(pause), .step(step), .led_out(led_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] led; int at; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && frame_tick) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected (led %0h)", cyc, led_out);
      end else begin
        e = sb.pop_front();
        chk("frame_led", 32'(led_out), 32'(e.led));
        chk("frame_cycle", cyc, e.at);
      end
    end
  end

  // Reference model: frame index plus position/value trackers, one per pattern family.
  int       m_pat, m_n, m_pos, m_cnt;
  bit [7:0] m_lfsr;

  function automatic logic [7:0] model_img();
    int idx, p, k, ones;
    case (m_pat)
      1: return 8'(1 << m_pos);
      2: return ~8'(1 << m_pos);
      3: begin
        idx = m_n % (2 * W - 2);
        p   = (idx < W) ? idx : (2 * W - 2 - idx);
        return 8'(1 << p);
      end
      4: return 8'(m_cnt);
      5: begin
        k    = m_n % (2 * W);
        ones = (k <= W) ? k : (2 * W - k);
        return 8'((1 << ones) - 1);
      end
      6: return (m_n % 2 == 0) ? 8'hFF : 8'h00;
      7: return m_lfsr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_load(input int p);
    m_pat = p; m_n = 0; m_pos = 0; m_cnt = 0; m_lfsr = 8'h01;
  endtask

  task automatic model_adv(input logic d);
    m_n++;
    m_pos = d ? (m_pos + W - 1) % W : (m_pos + 1) % W;
    m_cnt = d ? (m_cnt + 255) % 256 : (m_cnt + 1) % 256;
    if (m_lfsr == 8'h00) m_lfsr = 8'h01;
    else m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic push_next(input int at);
    model_adv(dir);
    sb.push_back('{led: model_img(), at: at});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  bit seen[256];
  int distinct;

  // Called at a negedge: select pattern p, check the seed, then expect nf frames.
  task automatic run_seg(input int p, input int s, input int nf, input bit dir_rand, input int flip_at);
    int L, P;
    pat_sel = 3'(p);
    speed   = 2'(s);
    ena     = 1'b1;
    L = cyc + 1;
    P = BD << s;
    model_load(p);
    if (p == 7) begin
      foreach (seen[i]) seen[i] = 1'b0;
      distinct = 0;
    end
    @(negedge clk);
    chk("load_led", 32'(led_out), 32'(model_img()));
    chk("load_no_tick", 32'(frame_tick), 32'd0);
    for (int j = 1; j <= nf; j++) begin
      if (dir_rand) dir = 1'($urandom_range(1, 0));
      else if (j == flip_at) dir = ~dir;
      push_next(L + j * P);
      wait_until(L + j * P);
      if (p == 7 && !seen[led_out]) begin
        seen[led_out] = 1'b1;
        distinct++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int c, u, t, np;
    ena = 1'b1;
    pat_sel = 3'd1;
    #12;
    chk("reset_led", 32'(led_out), 32'd0);
    chk("reset_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seg(1, 0, 10, 1'b0, 9);      // walking one, flip to right at 01
    run_seg(3, 0, 16, 1'b0, -1);     // ping-pong full period plus two
    run_seg(5, 0, 17, 1'b0, -1);     // bar fill/empty

    // Asynchronous reset between clock edges.
    repeat (2) @(negedge clk);
    chk("pre_reset_nonzero", 32'(led_out != 8'h00), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_led", 32'(led_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dir = 1'b1;
    run_seg(4, 0, 3, 1'b0, -1);      // counter down from reset: 00, FF, FE, FD
    dir = 1'b0;
    run_seg(7, 0, 255, 1'b0, -1);
    chk("lfsr_distinct", distinct, 255);
    chk("lfsr_wrap", 32'(led_out), 32'h01);

    // Pause, single step, resume.
    run_seg(3, 0, 3, 1'b0, -1);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    v = led_out;
    repeat (100) @(negedge clk);
    chk("pause_hold", 32'(led_out), 32'(v));
    c = cyc;
    step = 1'b1;
    push_next(c + 2);
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    chk("step_once", 32'(led_out), 32'(model_img()));
    u = cyc;
    pause = 1'b0;
    push_next(u + 4);
    wait_until(u + 4);
    // Pause landing on terminal count: count is kept and fires on resume.
    repeat (3) @(negedge clk);
    pause = 1'b1;
    repeat (10) @(negedge clk);
    chk("pause_tc_hold", 32'(led_out), 32'(model_img()));
    u = cyc;
    pause = 1'b0;
    push_next(u + 1);
    wait_until(u + 1);

    // Speed changes without reload.
    t = cyc;
    speed = 2'd3;
    push_next(t + 32);
    push_next(t + 64);
    wait_until(t + 64);
    repeat (10) @(negedge clk);
    t = cyc;
    speed = 2'd0;
    push_next(t + 1);
    push_next(t + 5);
    wait_until(t + 5);

    // ena low freezes everything, including a pending pattern change.
    v = led_out;
    ena = 1'b0;
    pat_sel = 3'd6;
    repeat (20) @(negedge clk);
    chk("ena_hold", 32'(led_out), 32'(v));
    run_seg(6, 0, 4, 1'b0, -1);

    // Pattern change mid-frame, then a change on the terminal-count edge.
    run_seg(1, 0, 3, 1'b0, -1);
    repeat (2) @(negedge clk);
    run_seg(6, 0, 2, 1'b0, -1);
    run_seg(2, 1, 3, 1'b1, -1);
    repeat (7) @(negedge clk);
    run_seg(4, 0, 3, 1'b1, -1);

    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range((BD << speed) - 1, 0)) @(negedge clk);
      np = (int'(pat_sel) + 1 + int'($urandom_range(6, 0))) % 8;
      run_seg(np, int'($urandom_range(2, 0)), int'($urandom_range(13, 2)), 1'b1, -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
